uart_tx_fifo: RTL and testbench

Memory-mapped UART transmitter with an on-chip byte FIFO, sitting on the core's data-memory port beside main memory. The core stores bytes to the TX data register. The block buffers them and serialises each one as an 8N1 frame on uart_out. A status register lets software poll FIFO occupancy instead of spinning on a single-byte transmitter.

---
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: a DEPTH-entry byte FIFO feeding an 8N1 serialiser.
// TXDATA at offset 0x0 and STATUS at offset 0x4, with a registered read port.
module uart_tx_fifo #(
    parameter int WAIT_DIV = 868,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_DIV > 1) ? $clog2(WAIT_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(WAIT_DIV - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    shift_reg;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;

    logic push_req, push_ok, pop, ovf_clr, baud_done;
    logic full, empty, busy;
    logic [31:0] status;
    logic unused_bits;

    assign push_req  = sel && wen && !addr[2];
    assign ovf_clr   = sel && wen && addr[2] && wdata[3];
    assign pop       = (state == IDLE) && (count != '0);
    // A full FIFO still takes a push when the serialiser frees a slot this cycle.
    assign push_ok   = push_req && ((count != FULL_CNT) || pop);
    assign baud_done = (baud == BAUD_LAST);

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign busy   = (state != IDLE);
    assign status = {23'b0, 5'(count), overflow, busy, empty, full};

    assign unused_bits = ^{addr[31:3], addr[1:0], wdata[31:8]};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A dropped push outranks a concurrent clear.
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            uart_out  <= 1'b1;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_out <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud      <= '0;
                        uart_out  <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud     <= '0;
                        bit_idx  <= '0;
                        uart_out <= shift_reg[0];
                        state    <= DATA;
                    end else baud <= baud + 1'b1;
                end
                DATA: begin
                    if (baud_done) begin
                        baud      <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        // Output is registered, so present the next bit as the shift happens.
                        if (bit_idx == 3'd7) begin
                            uart_out <= 1'b1;
                            state    <= STOP;
                        end else uart_out <= shift_reg[1];
                    end else baud <= baud + 1'b1;
                end
                STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else baud <= baud + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= (sel && addr[2]) ? status : '0;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue/frame-position model is compared every cycle,
// plus literal expectations for waveforms, STATUS words and decoded bytes.
module tb_uart_tx_fifo;
    localparam int W = 4;
    localparam int D = 8;

    logic        clk = 0;
    logic        rst = 1;
    logic        sel = 0, wen = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata;
    logic        uart_out;

    uart_tx_fifo #(.WAIT_DIV(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wen(wen),
        .wdata(wdata), .rdata(rdata), .uart_out(uart_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: byte queue plus position within the current frame (-1 = line idle).
    logic [7:0]  m_q[$];
    int          m_fpos = -1;
    int          m_k;
    logic [7:0]  m_cur = 0;
    bit          m_ovf = 0;
    logic        m_line = 1;
    logic [31:0] m_rdata = 0;
    logic [31:0] m_st;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_q.delete();
            m_fpos = -1; m_ovf = 0; m_line = 1; m_rdata = 0;
        end else begin
            m_st = 0;
            m_st[0]   = (m_q.size() == D);
            m_st[1]   = (m_q.size() == 0);
            m_st[2]   = (m_fpos >= 0);
            m_st[3]   = m_ovf;
            m_st[8:4] = 5'(m_q.size());
            m_rdata = (sel && addr[2]) ? m_st : 32'h0;
            if (m_fpos < 0 && m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_fpos = 0;
            end else if (m_fpos >= 0) begin
                m_fpos++;
                if (m_fpos == 10*W) m_fpos = -1;
            end
            m_k = (m_fpos < 0) ? 9 : m_fpos / W;
            m_line = (m_k == 0) ? 1'b0 : (m_k == 9) ? 1'b1 : m_cur[m_k-1];
            if (sel && wen && !addr[2]) begin
                if (m_q.size() < D) m_q.push_back(wdata[7:0]);
                else m_ovf = 1;
            end else if (sel && wen && addr[2] && wdata[3]) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("line", {31'b0, uart_out}, {31'b0, m_line});
            chk("rdata", rdata, m_rdata);
        end
    end

    // Line decoder sampling mid-bit, independent of the model.
    logic [7:0] rxq[$];
    logic [7:0] rx_sh = 0;
    bit rx_act = 0;
    int rx_t = 0;
    logic rx_prev = 1;
    always @(negedge clk) begin
        if (rst) rx_act = 0;
        else if (!rx_act) begin
            if (uart_out === 1'b0 && rx_prev === 1'b1) begin rx_act = 1; rx_t = 0; end
        end else begin
            rx_t++;
            if (rx_t % W == W/2 && rx_t / W >= 1 && rx_t / W <= 8) rx_sh = {uart_out, rx_sh[7:1]};
            if (rx_t == 9*W + W/2) begin rxq.push_back(rx_sh); rx_act = 0; end
        end
        rx_prev = uart_out;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic drive(input logic s, input logic [31:0] a, input logic w, input logic [31:0] d);
        sel = s; addr = a; wen = w; wdata = d;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1, a, 1, d); step(); drive(0, 0, 0, 0);
    endtask
    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        drive(1, a, 0, 0); step(); drive(0, 0, 0, 0);
        @(negedge clk); v = rdata;
        step();
    endtask
    task automatic wait_idle(input string nm);
        int n = 0;
        while ((m_fpos >= 0 || m_q.size() != 0) && n < 2000) begin step(); n++; end
        step();
        chk(nm, {31'b0, n < 2000}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [43:0] cap;
        logic [7:0]  exp_rx[3];
        int t0;
        bit went_low;

        drive(0, 0, 0, 0);
        step(); chk_en = 1;
        step(); step();
        rst = 0;
        step();
        chk("reset_line", {31'b0, uart_out}, 32'h1);
        rd(32'h4, v); chk("reset_status", v, 32'h2);

        // 1: single 0x55 frame, waveform pinned bit by bit
        cap = '0;
        wr(32'h0, 32'h55);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) chk("t1_pop_cycle_high", {31'b0, uart_out}, 32'h1);
            else cap = {cap[42:0], uart_out};
            step();
        end
        chk("t1_wave", cap[31:0], 32'b1111_0000_1111_0000_1111_0000_1111_1111);
        chk("t1_wave_hi", {20'b0, cap[43:32]}, {20'b0, 12'b0000_1111_0000});
        rd(32'h4, v); chk("t1_status_idle", v, 32'h2);

        // 2: three back-to-back frames
        rxq.delete();
        wr(32'h0, 32'hA1); wr(32'h0, 32'hB2); wr(32'h0, 32'hC3);
        rd(32'h4, v); chk("t2_count2", v, 32'h24);
        wait_idle("t2_drain");
        exp_rx = '{8'hA1, 8'hB2, 8'hC3};
        chk("t2_rx_count", rxq.size(), 3);
        for (int i = 0; i < 3 && i < rxq.size(); i++) chk("t2_rx_byte", {24'b0, rxq[i]}, {24'b0, exp_rx[i]});

        // 3: overflow with the serialiser busy on 0x00
        t0 = cyc;
        for (int i = 0; i < D + 2; i++) wr(32'h0, i);
        rd(32'h4, v); chk("t3_full_ovf", v, 32'h8D);
        wr(32'h4, 32'h8);
        rd(32'h4, v); chk("t3_ovf_cleared", v, 32'h85);

        // 4: push on the pop cycle of a full FIFO
        while (cyc < t0 + 42) step();
        wr(32'h0, 32'hEE);
        rd(32'h4, v); chk("t4_push_on_pop", v, 32'h85);

        // 5: read latency and sel gating
        drive(1, 32'h4, 0, 0);
        @(negedge clk); chk("t5_pre", rdata, 32'h0);
        step(); drive(0, 0, 0, 0);
        @(negedge clk); chk("t5_valid", rdata, 32'h85);
        step();
        @(negedge clk); chk("t5_after", rdata, 32'h0);
        step();
        rd(32'h0, v); chk("t5_txdata_reads0", v, 32'h0);
        wait_idle("t5_drain");

        // 6: reset mid-frame with bytes queued
        rxq.delete();
        t0 = cyc;
        wr(32'h0, 32'h3C); wr(32'h0, 32'h11); wr(32'h0, 32'h22); wr(32'h0, 32'h33);
        while (cyc < t0 + 12) step();
        rst = 1; step(); rst = 0;
        @(negedge clk); chk("t6_line_high", {31'b0, uart_out}, 32'h1);
        step();
        rd(32'h4, v); chk("t6_status_flushed", v, 32'h2);
        went_low = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); if (uart_out !== 1'b1) went_low = 1;
            step();
        end
        chk("t6_no_frames", {31'b0, went_low}, 32'h0);
        chk("t6_rx_empty", rxq.size(), 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
